// File: rtl/display_reader.sv
// 640x480@60 raster generator that pops RGB444 pixels from the output FIFO.
// Optional colour-bar source enabled by defining TEST_PATTERN_EN.
module display_reader #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        o_rd,
  input  logic [11:0] i_data,
  input  logic        i_empty,
`ifdef TEST_PATTERN_EN
  input  logic        i_test_pattern,
`endif
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_rgb,
  output logic        o_frame_start,
  output logic        o_underflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [0:0] ST_WAIT   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic        h_wrap;
  logic        frame_end;
  logic        active;
  logic        pre_active;
  logic        start;
  logic        rd_q;
  logic        test_pat;
  logic [11:0] bar;

`ifdef TEST_PATTERN_EN
  assign test_pat = i_test_pattern;
`else
  assign test_pat = 1'b0;
`endif

  always_comb begin
    h_wrap     = (h_cnt == H_LAST);
    h_nxt      = h_wrap ? '0 : h_cnt + 10'd1;
    v_nxt      = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
    frame_end  = h_wrap && (v_cnt == V_LAST);
    active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    pre_active = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    // WAIT must already pop for pixel (0,0) in the cycle it leaves, or the
    // first word of the frame would land on pixel (1,0).
    start      = (state == ST_WAIT) && frame_end && !i_empty && !test_pat;
    o_rd       = !test_pat && pre_active && !i_empty && ((state == ST_STREAM) || start);
    state_nxt  = state;
    if (test_pat) begin
      state_nxt = ST_WAIT;
    end else if (start) begin
      state_nxt = ST_STREAM;
    end
    bar = {{4{h_cnt[8]}}, {4{h_cnt[7]}}, {4{h_cnt[6]}}};
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      state         <= ST_WAIT;
      rd_q          <= 1'b0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_de          <= 1'b0;
      o_rgb         <= '0;
      o_frame_start <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      state         <= state_nxt;
      rd_q          <= o_rd;
      o_hsync       <= !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
      o_vsync       <= !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
      o_de          <= active;
      o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
      if (!active) begin
        o_rgb <= '0;
      end else if (test_pat) begin
        o_rgb <= bar;
      end else if ((state == ST_STREAM) && rd_q) begin
        o_rgb <= i_data;
      end else begin
        o_rgb <= '0;
      end
      if ((state == ST_STREAM) && !test_pat && pre_active && i_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_reader.sv
// Scoreboard bench for display_reader on a shrunken raster (512x4 active).
// Build with TEST_PATTERN_EN defined to exercise the colour-bar source too.
module tb_display_reader;

  localparam int unsigned HA = 512, HF = 2, HS = 4, HB = 3;
  localparam int unsigned VA = 4,   VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned NPIX  = HA * VA;

  logic        clk;
  logic        rstn;
  logic        o_rd;
  logic [11:0] i_data;
  logic        i_empty;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [11:0] o_rgb;
  logic        o_frame_start;
  logic        o_underflow;
`ifdef TEST_PATTERN_EN
  logic        tp;
  logic [11:0] bar_tab [8] = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF,
                               12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};
`endif

  logic [11:0]  mem [8192];
  int unsigned  wr_ptr;
  int unsigned  rd_ptr;
  logic         fifo_clr;
  logic         hold_empty;
  logic         mon_en;
  logic         hole_en;
  logic         tog_en;
  int unsigned  h_ref;
  int unsigned  v_ref;
  int unsigned  frm_ref;
  logic [11:0]  sb [$];
  int           n_tests;
  int           n_fail;

  display_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .o_rd          (o_rd),
    .i_data        (i_data),
    .i_empty       (i_empty),
`ifdef TEST_PATTERN_EN
    .i_test_pattern(tp),
`endif
    .o_hsync       (o_hsync),
    .o_vsync       (o_vsync),
    .o_de          (o_de),
    .o_rgb         (o_rgb),
    .o_frame_start (o_frame_start),
    .o_underflow   (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic next_active(input int unsigned h, input int unsigned v);
    int unsigned nh;
    int unsigned nv;
    nh = h + 1;
    nv = v;
    if (nh == HT) begin
      nh = 0;
      nv = (v == VT - 1) ? 0 : v + 1;
    end
    return (nh < HA) && (nv < VA);
  endfunction

  // Hole: no data for pixels 100..103 of line 2 in frame 1; toggle: empty only in blanking
  assign hold_empty = (hole_en && frm_ref == 1 && v_ref == 2 && h_ref >= 99 && h_ref <= 102) ||
                      (tog_en && !next_active(h_ref, v_ref) && (h_ref % 2 == 1));
  assign i_empty = hold_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd_ptr <= 0;
      i_data <= '0;
    end else if (o_rd) begin
      i_data <= mem[rd_ptr % 8192];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_ref   <= 0;
      v_ref   <= 0;
      frm_ref <= 0;
    end else if (h_ref == HT - 1) begin
      h_ref <= 0;
      if (v_ref == VT - 1) begin
        v_ref   <= 0;
        frm_ref <= frm_ref + 1;
      end else begin
        v_ref <= v_ref + 1;
      end
    end else begin
      h_ref <= h_ref + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (rstn === 1'b1) begin
      if (i_empty) chk("no_pop_when_empty", int'(o_rd), 0);
      if (mon_en && o_de) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pixel_extra: got rgb 0x%03h, required no pixel (scoreboard empty)", o_rgb);
        end else begin
          e = sb.pop_front();
          chk("pixel", int'(o_rgb), int'(e));
        end
      end
    end
  end

  task automatic push_const(input logic [11:0] val, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sb.push_back(val);
  endtask

  task automatic push_mem(input int unsigned base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) sb.push_back(mem[(base + i) % 8192]);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rd"},          int'(o_rd), 0);
    chk({tag, "_hsync"},       int'(o_hsync), 1);
    chk({tag, "_vsync"},       int'(o_vsync), 1);
    chk({tag, "_de"},          int'(o_de), 0);
    chk({tag, "_rgb"},         int'(o_rgb), 0);
    chk({tag, "_frame_start"}, int'(o_frame_start), 0);
    chk({tag, "_underflow"},   int'(o_underflow), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    mon_en   = 1'b0;
    hole_en  = 1'b0;
    tog_en   = 1'b0;
`ifdef TEST_PATTERN_EN
    tp       = 1'b0;
`endif
    fifo_clr = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    fifo_clr = 1'b0;
    wr_ptr   = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int unsigned lim);
    int unsigned n = 0;
    while (sb.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected pixels never appeared, required 0 outstanding", name, sb.size());
    end
  endtask

  task automatic wait_pos(input string name, input int unsigned f, input int unsigned v,
                          input int unsigned h, input int unsigned lim);
    int unsigned n = 0;
    while (!(frm_ref == f && v_ref == v && h_ref == h) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!(frm_ref == f && v_ref == v && h_ref == h)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: position f%0d v%0d h%0d not reached in %0d cycles", name, f, v, h, lim);
    end
  endtask

  initial begin : stim
    int          rd_c, de_c, hs_c, vs_c, fs_c, de_first, hs_first;
    int unsigned k, r0;
    n_tests  = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    fifo_clr = 1'b1;
    wr_ptr   = 0;
    mon_en   = 1'b0;
    hole_en  = 1'b0;
    tog_en   = 1'b0;
`ifdef TEST_PATTERN_EN
    tp       = 1'b0;
`endif
    for (int unsigned i = 0; i < 8192; i++) mem[i] = 12'(i % 4096);
    repeat (3) @(negedge clk);
    fifo_clr = 1'b0;

    // Test 1: empty FIFO, one frame of raster timing
    check_reset("t1_reset");
    push_const('0, NPIX);
    mon_en = 1'b1;
    rstn   = 1'b1;
    rd_c = 0; de_c = 0; hs_c = 0; vs_c = 0; fs_c = 0; de_first = -1; hs_first = -1;
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk);
      if (o_rd) rd_c++;
      if (o_de) begin
        de_c++;
        if (de_first < 0) de_first = i;
      end
      if (!o_hsync) begin
        hs_c++;
        if (hs_first < 0) hs_first = i;
      end
      if (!o_vsync) vs_c++;
      if (o_frame_start) fs_c++;
    end
    chk("t1_rd_count", rd_c, 0);
    chk("t1_de_count", de_c, int'(NPIX));
    chk("t1_hsync_low", hs_c, int'(HS * VT));
    chk("t1_vsync_low", vs_c, int'(VS * HT));
    chk("t1_frame_start", fs_c, 1);
    chk("t1_hsync_after_de", hs_first - de_first, int'(HA + HF));
    chk("t1_sb_drained", sb.size(), 0);
    mon_en = 1'b0;

    // Test 2: preloaded frame; frame 0 black, frame 1 streams the words in order
    do_reset();
    wr_ptr = NPIX;
    push_const('0, NPIX);
    push_mem(0, NPIX);
    mon_en = 1'b1;
    release_reset();
    wait_drain("t2_drain", 3 * FRAME);
    chk("t2_underflow", int'(o_underflow), 0);
    chk("t2_pop_count", int'(rd_ptr), int'(NPIX));

    // Test 3: four-pixel hole on line 2 of frame 1
    do_reset();
    wr_ptr = NPIX;
    push_const('0, NPIX);
    k = 0;
    for (int unsigned i = 0; i < NPIX; i++) begin
      if (i / HA == 2 && i % HA >= 100 && i % HA <= 103) begin
        sb.push_back('0);
      end else begin
        sb.push_back(mem[k]);
        k++;
      end
    end
    hole_en = 1'b1;
    mon_en  = 1'b1;
    release_reset();
    wait_pos("t3_pre_hole", 1, 2, 50, 3 * FRAME);
    chk("t3_underflow_before", int'(o_underflow), 0);
    wait_drain("t3_drain", 2 * FRAME);
    chk("t3_underflow_sticky", int'(o_underflow), 1);
    chk("t3_pop_count", int'(rd_ptr), int'(NPIX - 4));

    // Test 4: asynchronous reset in the middle of a streamed frame
    do_reset();
    wr_ptr = 2 * NPIX;
    release_reset();
    wait_pos("t4_reach", 1, 2, 300, 3 * FRAME);
    rstn = 1'b0;
    #1;
    check_reset("t4_async");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rd_c = 0;
    for (int i = 0; i < int'(FRAME) - 2; i++) begin
      @(negedge clk);
      if (o_rd) rd_c++;
    end
    chk("t4_no_rd_before_boundary", rd_c, 0);
    @(negedge clk);
    chk("t4_rd_at_boundary", int'(o_rd), 1);
    r0 = rd_ptr;
    push_mem(r0, NPIX);
    mon_en = 1'b1;
    wait_drain("t4_drain", 2 * FRAME);
    chk("t4_underflow", int'(o_underflow), 0);

`ifdef TEST_PATTERN_EN
    // Test 5: colour bars with a non-empty FIFO that must stay untouched
    do_reset();
    wr_ptr = NPIX;
    tp     = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int unsigned i = 0; i < NPIX; i++) sb.push_back(bar_tab[(i % HA) / 64]);
    mon_en = 1'b1;
    release_reset();
    rd_c = 0;
    for (int i = 0; i < 2 * int'(FRAME); i++) begin
      @(negedge clk);
      if (o_rd) rd_c++;
    end
    chk("t5_rd_count", rd_c, 0);
    wait_drain("t5_drain", FRAME);
    chk("t5_pop_count", int'(rd_ptr), 0);
    chk("t5_underflow", int'(o_underflow), 0);
`endif

    // Test 6: i_empty toggling only while the next position is blanking
    do_reset();
    wr_ptr = 2 * NPIX;
    tog_en = 1'b1;
    push_const('0, NPIX);
    push_mem(0, 2 * NPIX);
    mon_en = 1'b1;
    release_reset();
    wait_pos("t6_end_frame1", 1, VT - 1, HT - 1, 3 * FRAME);
    chk("t6_pops_frame1", int'(rd_ptr), int'(NPIX));
    wait_drain("t6_drain", 2 * FRAME);
    chk("t6_underflow", int'(o_underflow), 0);
    chk("t6_pop_count", int'(rd_ptr), int'(2 * NPIX));

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
